// File: rtl/fsqrt_share_arb.sv
// Round-robin arbiter sharing one multicycle combinational fsqrt among NREQ requesters.
// Optional FSQRT_ARB_FASTPATH_EN: special operands are answered from IDLE without the CALC wait.
module fsqrt_share_arb #(
    parameter int unsigned NREQ        = 4,
    parameter int unsigned CALC_CYCLES = 3,
    parameter int unsigned IDW         = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [32*NREQ-1:0]   req_x,
    output logic [NREQ-1:0]      req_ready,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [31:0]          resp_y,
    output logic [IDW-1:0]       resp_id,
    output logic                 busy
);

    localparam int unsigned CW = (CALC_CYCLES > 1) ? $clog2(CALC_CYCLES) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    // Correctly rounded (RNE) single-precision square root, subnormal inputs included.
    function automatic logic [31:0] fsqrt(input logic [31:0] x);
        logic              s;
        logic [7:0]        e;
        logic [22:0]       m;
        logic [23:0]       mant;
        logic signed [8:0] exp_u;
        logic [47:0]       rad;
        logic [23:0]       root;
        logic [26:0]       rem;
        logic [26:0]       trial;
        logic [7:0]        exp_r;
        s     = x[31];
        e     = x[30:23];
        m     = x[22:0];
        mant  = '0;
        exp_u = '0;
        rad   = '0;
        root  = '0;
        rem   = '0;
        trial = '0;
        exp_r = '0;
        fsqrt = 32'h0;
        if (e == 8'hFF && m != 23'd0) begin
            fsqrt = {s, 8'hFF, 1'b1, m[21:0]};
        end else if (x == 32'h7F80_0000) begin
            fsqrt = x;
        end else if (e == 8'd0 && m == 23'd0) begin
            fsqrt = x;
        end else if (s) begin
            fsqrt = 32'hFFC0_0000;
        end else begin
            if (e == 8'd0) begin
                mant  = {1'b0, m};
                exp_u = -9'sd126;
                for (int i = 0; i < 23; i++) begin
                    if (!mant[23]) begin
                        mant  = mant << 1;
                        exp_u = exp_u - 9'sd1;
                    end
                end
            end else begin
                mant  = {1'b1, m};
                exp_u = $signed({1'b0, e}) - 9'sd127;
            end
            // Make the exponent even so the root's exponent is an exact halving.
            if (exp_u[0]) begin
                rad   = {mant, 24'b0};
                exp_u = exp_u - 9'sd1;
            end else begin
                rad   = {1'b0, mant, 23'b0};
            end
            for (int i = 23; i >= 0; i--) begin
                rem   = {rem[24:0], rad[2*i+1 -: 2]};
                trial = {1'b0, root, 2'b01};
                if (rem >= trial) begin
                    rem  = rem - trial;
                    root = {root[22:0], 1'b1};
                end else begin
                    root = {root[22:0], 1'b0};
                end
            end
            // Remainder above root means the true root lies past root+0.5; ties cannot occur.
            if (rem > {3'b0, root}) begin
                root = root + 24'd1;
            end
            exp_r = 8'(exp_u >>> 1) + 8'd126 + {7'b0, root[23]};
            fsqrt = {1'b0, exp_r, root[22:0]};
        end
    endfunction

    logic [1:0]     state_q, state_d;
    logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [31:0]    x_q, x_d;
    logic [31:0]    y_q, y_d;
    logic [IDW-1:0] id_q, id_d;
    logic           resp_valid_q, resp_valid_d;

    logic           gnt_found;
    logic [IDW-1:0] gnt_idx;
    logic [31:0]    gnt_x;
    logic [31:0]    sqrt_y;
    logic [IDW-1:0] next_ptr;
    int unsigned    idx;

    // Round-robin search starting at rr_ptr.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        idx       = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (32'(rr_ptr_q) + 32'(k)) % NREQ;
            if (!gnt_found && req_valid[IDW'(idx)]) begin
                gnt_found = 1'b1;
                gnt_idx   = IDW'(idx);
            end
        end
    end

    always_comb begin
        gnt_x = req_x[32'(gnt_idx)*32 +: 32];
    end

    always_comb begin
        req_ready = '0;
        if (!rst && state_q == S_IDLE && gnt_found) begin
            req_ready[gnt_idx] = 1'b1;
        end
    end

    // The sqrt datapath sees only the held operand, so it can be constrained as a multicycle path.
    always_comb begin
        sqrt_y = fsqrt(x_q);
    end

    always_comb begin
        next_ptr = (id_q == IDW'(NREQ - 1)) ? '0 : id_q + IDW'(1);
    end

`ifdef FSQRT_ARB_FASTPATH_EN
    // Returns {hit, result} for operands whose root needs no arithmetic.
    function automatic logic [32:0] fast_path(input logic [31:0] x);
        fast_path = {1'b0, 32'h0};
        if (x[30:23] == 8'hFF && x[22:0] != 23'd0) begin
            fast_path = {1'b1, x[31], 8'hFF, 1'b1, x[21:0]};
        end else if (x == 32'h7F80_0000 || x == 32'h0000_0000 || x == 32'h8000_0000) begin
            fast_path = {1'b1, x};
        end else if (x[31]) begin
            fast_path = {1'b1, 32'hFFC0_0000};
        end
    endfunction

    logic [32:0] fast;
    always_comb begin
        fast = fast_path(gnt_x);
    end
`endif

    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        cnt_d        = cnt_q;
        x_d          = x_q;
        y_d          = y_q;
        id_d         = id_q;
        resp_valid_d = resp_valid_q;
        case (state_q)
            S_IDLE: begin
                if (gnt_found) begin
                    x_d     = gnt_x;
                    id_d    = gnt_idx;
                    cnt_d   = CW'(CALC_CYCLES - 1);
                    state_d = S_CALC;
`ifdef FSQRT_ARB_FASTPATH_EN
                    if (fast[32]) begin
                        y_d          = fast[31:0];
                        resp_valid_d = 1'b1;
                        state_d      = S_RESP;
                    end
`endif
                end
            end
            S_CALC: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    y_d          = sqrt_y;
                    resp_valid_d = 1'b1;
                    state_d      = S_RESP;
                end
            end
            S_RESP: begin
                if (resp_ready) begin
                    resp_valid_d = 1'b0;
                    rr_ptr_d     = next_ptr;
                    state_d      = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            rr_ptr_q     <= '0;
            cnt_q        <= '0;
            x_q          <= '0;
            y_q          <= '0;
            id_q         <= '0;
            resp_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            cnt_q        <= cnt_d;
            x_q          <= x_d;
            y_q          <= y_d;
            id_q         <= id_d;
            resp_valid_q <= resp_valid_d;
        end
    end

    assign resp_valid = resp_valid_q;
    assign resp_y     = y_q;
    assign resp_id    = id_q;
    assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_fsqrt_share_arb.sv
// Randomized self-checking bench for fsqrt_share_arb against an arithmetic sqrt and round-robin model.
module tb_fsqrt_share_arb;

    localparam int unsigned NREQ = 4;
    localparam int unsigned CALC = 3;
    localparam int unsigned IDW  = 2;
`ifdef FSQRT_ARB_FASTPATH_EN
    localparam int FAST_LAT = 1;
`else
    localparam int FAST_LAT = CALC + 1;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req_valid;
    logic [31:0]       xs [NREQ];
    logic [32*NREQ-1:0] req_x;
    logic [NREQ-1:0]   req_ready;
    logic              resp_valid;
    logic              resp_ready;
    logic [31:0]       resp_y;
    logic [IDW-1:0]    resp_id;
    logic              busy;

    int n_checks = 0;
    int n_fails  = 0;
    int rr       = 0;

    always #5 clk = ~clk;

    always_comb begin
        req_x = {xs[3], xs[2], xs[1], xs[0]};
    end

    fsqrt_share_arb #(.NREQ(NREQ), .CALC_CYCLES(CALC)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_x      (req_x),
        .req_ready  (req_ready),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_y     (resp_y),
        .resp_id    (resp_id),
        .busy       (busy)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Exact integer square root by bisection.
    function automatic longint unsigned isqrt(input longint unsigned n);
        longint unsigned lo = 0;
        longint unsigned hi = 64'd1 << 24;
        longint unsigned mid;
        while (hi - lo > 1) begin
            mid = (lo + hi) / 2;
            if (mid * mid <= n) lo = mid;
            else hi = mid;
        end
        return lo;
    endfunction

    function automatic bit ref_special(input logic [31:0] x);
        return (x[30:23] == 8'hFF) || (x[30:0] == 31'd0) || x[31];
    endfunction

    function automatic logic [31:0] ref_sqrt(input logic [31:0] x);
        logic [7:0]      e;
        logic [22:0]     m;
        longint unsigned mant, n, q;
        int              ex;
        e = x[30:23];
        m = x[22:0];
        if (e == 8'hFF && m != 0) return {x[31], 8'hFF, 1'b1, m[21:0]};
        if (x == 32'h7F80_0000) return x;
        if (x[30:0] == 31'd0) return x;
        if (x[31]) return 32'hFFC0_0000;
        if (e == 0) begin
            mant = 64'(m);
            ex   = -126;
            while (mant < (64'd1 << 23)) begin
                mant = mant * 2;
                ex   = ex - 1;
            end
        end else begin
            mant = 64'(m) + (64'd1 << 23);
            ex   = int'(e) - 127;
        end
        if ((ex % 2) != 0) begin
            n  = mant << 24;
            ex = ex - 1;
        end else begin
            n = mant << 23;
        end
        q = isqrt(n);
        if (n - q * q > q) q = q + 1;
        return {1'b0, 8'(ex / 2 + 127), q[22:0]};
    endfunction

    function automatic int ref_grant(input logic [NREQ-1:0] mask);
        for (int k = 0; k < NREQ; k++) begin
            int j;
            j = (rr + k) % NREQ;
            if (mask[j]) return j;
        end
        return -1;
    endfunction

    function automatic logic [31:0] gen_x();
        logic [31:0] r;
        logic [31:0] sp [7];
        sp = '{32'h7F80_0000, 32'hFF80_0000, 32'h0, 32'h8000_0000,
               32'h7FC0_0001, 32'hFF81_2345, 32'h7F80_0001};
        r = $urandom();
        case ($urandom_range(0, 5))
            0:       return r;
            1:       return {1'b0, r[30:0]};
            2:       return {9'b0, r[22:0]};
            3:       return sp[$urandom_range(0, 6)];
            4:       return {1'b0, 8'($urandom_range(1, 254)), 23'b0};
            default: return {1'b0, 8'hFE, r[22:0]};
        endcase
    endfunction

    // Called at a negedge with the arbiter idle; ends at a negedge after the response handshake.
    task automatic run_op(input logic [NREQ-1:0] mask, input int hold, input bit keep);
        int          g;
        int          k;
        int          lat;
        logic [31:0] x;
        logic [31:0] y;
        req_valid  = mask;
        resp_ready = (hold == 0);
        g = ref_grant(mask);
        #1;
        check_eq("grant", 32'(req_ready), 32'(1) << g);
        check_eq("busy_idle", 32'(busy), 32'd0);
        x   = xs[g];
        y   = ref_sqrt(x);
        lat = ref_special(x) ? FAST_LAT : int'(CALC) + 1;
        @(posedge clk);
        #1;
        if (!keep) req_valid[g] = 1'b0;
        k = 0;
        while (k < 20) begin
            @(negedge clk);
            k++;
            if (resp_valid) break;
            check_eq("ready_in_calc", 32'(req_ready), 32'd0);
        end
        check_eq("latency", 32'(k), 32'(lat));
        check_eq("resp_y", resp_y, y);
        check_eq("resp_id", 32'(resp_id), 32'(g));
        check_eq("ready_in_resp", 32'(req_ready), 32'd0);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check_eq("hold_valid", 32'(resp_valid), 32'd1);
            check_eq("hold_y", resp_y, y);
            check_eq("hold_id", 32'(resp_id), 32'(g));
            check_eq("hold_ready", 32'(req_ready), 32'd0);
            check_eq("hold_busy", 32'(busy), 32'd1);
        end
        resp_ready = 1'b1;
        @(posedge clk);
        rr = (g + 1) % NREQ;
        @(negedge clk);
        check_eq("resp_drop", 32'(resp_valid), 32'd0);
        check_eq("busy_after", 32'(busy), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;
        rst        = 1'b1;
        req_valid  = '1;
        resp_ready = 1'b1;
        for (int i = 0; i < NREQ; i++) xs[i] = 32'h4080_0000;
        repeat (3) @(negedge clk);
        #1;
        check_eq("rst_ready", 32'(req_ready), 32'd0);
        check_eq("rst_valid", 32'(resp_valid), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_y", resp_y, 32'd0);
        check_eq("rst_id", 32'(resp_id), 32'd0);
        @(negedge clk);
        rst       = 1'b0;
        req_valid = '0;
        @(negedge clk);

        // 4.0 from requester 0, then 2.0 from requester 2
        xs[0] = 32'h4080_0000;
        run_op(4'b0001, 0, 1'b0);
        xs[2] = 32'h4000_0000;
        run_op(4'b0100, 0, 1'b0);

        // Reset during CALC discards the operation and the round-robin pointer
        req_valid = 4'b0100;
        #1;
        check_eq("pre_rst_grant", 32'(req_ready), 32'b0100);
        @(posedge clk);
        #1;
        req_valid = '0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        rr  = 0;
        seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (resp_valid || busy) seen++;
        end
        check_eq("no_resp_after_rst", 32'(seen), 32'd0);
        xs[0] = 32'h4080_0000;
        xs[3] = 32'h4100_0000;
        run_op(4'b1001, 0, 1'b0);

        // Bring the pointer back to 0, then contend with all four
        run_op(4'b1000, 0, 1'b0);
        for (int i = 0; i < NREQ; i++) xs[i] = 32'h4080_0000;
        repeat (5) run_op(4'b1111, 0, 1'b1);

        // Stalled response consumer
        xs[1] = 32'h4110_0000;
        run_op(4'b1111, 5, 1'b1);

        // -1.0 yields the default quiet NaN
        xs[1] = 32'hBF80_0000;
        run_op(4'b0010, 0, 1'b0);

        repeat (150) begin
            for (int i = 0; i < NREQ; i++) xs[i] = gen_x();
            run_op(4'($urandom_range(1, 15)),
                   ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0,
                   1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
